// File: rtl/seq_mult_nxm_pkg.sv
// Shared types and default widths for the sequential N x M shift-add multiplier.
package MULT_PKG;

  localparam int DEF_A_WIDTH     = 8;
  localparam int DEF_B_WIDTH     = 8;
  localparam int STATE_REG_WIDTH = 2;

  typedef enum logic [STATE_REG_WIDTH-1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_nxm_dp.sv
// Multiplier datapath: operand capture, shift-add accumulator and result register.
// Signed (subtract-on-MSB) support is built only when MULT_SIGNED_EN is defined.
module seq_mult_nxm_dp #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic                       step_i,
  input  logic                       last_i,
  input  logic                       load_i,
  input  logic                       signed_i,
  input  logic [A_WIDTH-1:0]         a_i,
  input  logic [B_WIDTH-1:0]         b_i,
  output logic [A_WIDTH+B_WIDTH-1:0] y_o
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic [P_WIDTH-1:0] mcand_q, acc_q, y_q;
  logic [B_WIDTH-1:0] mplier_q;
  logic [P_WIDTH-1:0] a_ext, addend, acc_d;

`ifdef MULT_SIGNED_EN
  logic signed_q;

  always_comb begin
    a_ext  = signed_i ? {{B_WIDTH{a_i[A_WIDTH-1]}}, a_i} : {{B_WIDTH{1'b0}}, a_i};
    addend = mplier_q[0] ? mcand_q : '0;
    // MSB of a two's-complement multiplier carries negative weight
    acc_d  = (signed_q && last_i) ? (acc_q - addend) : (acc_q + addend);
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = signed_i ^ last_i;

  always_comb begin
    a_ext  = {{B_WIDTH{1'b0}}, a_i};
    addend = mplier_q[0] ? mcand_q : '0;
    acc_d  = acc_q + addend;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      y_q      <= '0;
`ifdef MULT_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      if (start_i) begin
        mcand_q  <= a_ext;
        mplier_q <= b_i;
        acc_q    <= '0;
`ifdef MULT_SIGNED_EN
        signed_q <= signed_i;
`endif
      end else if (step_i) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (load_i) y_q <= acc_q;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/seq_mult_nxm.sv
// Sequential N x M multiplier top: IDLE/CALC/DONE control FSM and iteration counter.
// Define MULT_SIGNED_EN to enable two's-complement operation via SIGNED_MODE.
module seq_mult_nxm
  import MULT_PKG::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH
) (
  input  logic                       SYS_CLOCK,
  input  logic                       FSM_SRESET_N,
  input  logic                       GO,
  input  logic                       SIGNED_MODE,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  output logic [A_WIDTH+B_WIDTH-1:0] Y_REG,
  output logic                       READY,
  output logic                       DONE
);

  localparam int CW = $clog2(B_WIDTH + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(B_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(B_WIDTH - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q, done_q;
  logic          start, step, last, load;

  assign start = (state_q == S_IDLE) && GO;
  assign step  = (state_q == S_CALC) && (cnt_q != CNT_DONE);
  assign last  = (cnt_q == CNT_LAST);
  assign load  = (state_q == S_CALC) && (cnt_q == CNT_DONE);

  // The counter reaching B_WIDTH spends one extra CALC cycle so Y_REG loads on DONE entry
  always_ff @(posedge SYS_CLOCK) begin
    if (!FSM_SRESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (GO) begin
            state_q <= S_CALC;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        S_CALC: begin
          if (cnt_q == CNT_DONE) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  seq_mult_nxm_dp #(
    .A_WIDTH(A_WIDTH),
    .B_WIDTH(B_WIDTH)
  ) u_dp (
    .clk_i   (SYS_CLOCK),
    .rst_n_i (FSM_SRESET_N),
    .start_i (start),
    .step_i  (step),
    .last_i  (last),
    .load_i  (load),
    .signed_i(SIGNED_MODE),
    .a_i     (A),
    .b_i     (B),
    .y_o     (Y_REG)
  );

  assign READY = ready_q;
  assign DONE  = done_q;

endmodule

// File: doc/seq_mult_nxm.md
SEQ_MULT_NXM -- requirements
Module: seq_mult_nxm

Interface
REQ-001 Parameter A_WIDTH, default 8, multiplicand width in bits (legal 2..32) SHALL be provided.
REQ-002 Parameter B_WIDTH, default 8, multiplier width in bits (legal 2..32) SHALL be provided.
REQ-003 SYS_CLOCK  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 FSM_SRESET_N  in  1  reset, synchronous and active-low, SHALL be sampled on the SYS_CLOCK rising edge.
REQ-005 GO  in  1  start request, sampled only in IDLE.
REQ-006 SIGNED_MODE  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-007 A  in  A_WIDTH  multiplicand.
REQ-008 B  in  B_WIDTH  multiplier.
REQ-009 Y_REG  out  A_WIDTH+B_WIDTH  registered product, held until the next completion.
REQ-010 READY  out  1  high only in IDLE.
REQ-011 DONE  out  1  one-cycle pulse, high in the cycle Y_REG first shows a new result.

Function
REQ-012 FSM states SHALL be IDLE, CALC and DONE, with no other reachable states.
REQ-013 IDLE, GO=1 at edge k: capture A, B and SIGNED_MODE into operand registers, clear the accumulator, clear the iteration counter, go to CALC.
REQ-014 IDLE, GO=0: remain in IDLE; operand registers unchanged.
REQ-015 CALC: one multiplier bit per cycle, LSB first; if the bit is 1, add the shifted multiplicand to the accumulator; counter increments; after B_WIDTH iterations (edge k+B_WIDTH) go to DONE.
REQ-016 Accumulator width SHALL be A_WIDTH+B_WIDTH; unsigned mode zero-extends the multiplicand; intermediate sums SHALL NOT overflow the accumulator.
REQ-017 Signed mode: multiplicand sign-extended; the final (MSB) iteration SHALL subtract instead of add; the result is the exact two's-complement product.
REQ-018 On entry to DONE (edge k+B_WIDTH+1), Y_REG SHALL load the accumulator and DONE SHALL be 1 for exactly that cycle.
REQ-019 DONE state SHALL return to IDLE on the next edge unconditionally; total GO-to-READY latency SHALL be B_WIDTH+2 cycles.
REQ-020 GO, A, B and SIGNED_MODE changes during CALC or DONE SHALL be ignored.
REQ-021 GO held high continuously SHALL start a new operation in every IDLE cycle, giving back-to-back operations with exactly one IDLE cycle between them.
REQ-022 Zero operands SHALL still take the full B_WIDTH iterations (no early termination).

Reset
REQ-023 FSM_SRESET_N=0 at an edge SHALL force IDLE, Y_REG=0, DONE=0, counter=0 and accumulator=0; READY=1 after that edge.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation; no DONE pulse SHALL follow and Y_REG SHALL read 0.
REQ-025 Reset SHALL take priority over GO at the same edge.

Configuration
REQ-026 Macro MULT_SIGNED_EN defined: signed mode per REQ-017 SHALL be available, selected by SIGNED_MODE.
REQ-027 Macro MULT_SIGNED_EN undefined: the SIGNED_MODE port SHALL remain present but be ignored, all operations SHALL be unsigned, and no subtract logic SHALL be synthesised.

Structure
REQ-028 Package MULT_PKG SHALL hold the state enum typedef, STATE_REG_WIDTH, and the default width constants used for A_WIDTH and B_WIDTH.
REQ-029 The datapath (operand registers, accumulator, adder/subtractor, Y_REG) SHALL be sub-module seq_mult_nxm_dp; the FSM and counter SHALL stay in seq_mult_nxm.

Verification (A_WIDTH=B_WIDTH=8, MULT_SIGNED_EN defined unless stated)
REQ-030 Unsigned max: A=0xFF, B=0xFF, SIGNED_MODE=0, GO pulse -> Y_REG=0xFE01 at edge k+9 with DONE=1; READY=1 at edge k+10.
REQ-031 Signed: A=0x80, B=0x80 -> Y_REG=0x4000; A=0xFF, B=0x01 -> Y_REG=0xFFFF; A=0x07, B=0xFE -> Y_REG=0xFFF2.
REQ-032 Ignored inputs: start with A=3, B=5; during CALC pulse GO and set A=0xFF -> Y_REG=0x000F, exactly one DONE pulse.
REQ-033 Reset mid-operation: start 0xFF*0xFF, drive FSM_SRESET_N=0 at iteration 4 -> next cycle READY=1, Y_REG=0x0000, no DONE pulse.
REQ-034 Back-to-back: GO held high, operands 7*2 then 0*200 -> Y_REG=0x000E then 0x0000, DONE pulses exactly 11 cycles apart.
REQ-035 Build without MULT_SIGNED_EN: A=0xFF, B=0xFF, SIGNED_MODE=1 -> Y_REG=0xFE01.
